// File: rtl/paged_mmu.sv
// rtl/paged_mmu.sv - paged data MMU with SR-programmed page table and sticky fault status (optional PAGED_MMU_NOCACHE_BIT_EN)
module paged_mmu #(
    parameter int RW         = 16,
    parameter int IN_ADDR_W  = 16,
    parameter int OUT_ADDR_W = 24,
    parameter int PAGE_IDX_W = 4,
    parameter logic [RW-1:0] SR_BASE = 16'h200,
    parameter logic [OUT_ADDR_W-IN_ADDR_W-1:0] DEFAULT_PREFIX = 8'h10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [IN_ADDR_W-1:0]  i_addr,
    output logic                  o_valid,
    output logic [OUT_ADDR_W-1:0] o_addr,
    output logic                  o_fault,
    output logic                  o_cacheable,
    input  logic [RW-1:0]         i_sr_addr,
    input  logic [RW-1:0]         i_sr_data,
    input  logic                  i_sr_we,
    output logic [RW-1:0]         o_sr_rdata,
    input  logic                  c_pag_en
);
    localparam int ENTRIES = 2 ** PAGE_IDX_W;
    localparam int OFF_W   = IN_ADDR_W - PAGE_IDX_W;
    localparam int PPN_W   = OUT_ADDR_W - OFF_W;

    localparam logic [RW-1:0] ENT_END = SR_BASE + RW'(ENTRIES);
    localparam logic [RW-1:0] FA_ADDR = ENT_END;
    localparam logic [RW-1:0] FC_ADDR = ENT_END + RW'(1);

    // Only V, W, (NC) and PPN bits are kept; everything else reads back as 0
    localparam logic [RW-1:0] PPN_MASK  = RW'((1 << PPN_W) - 1);
    localparam logic [RW-1:0] FLAG_MASK = RW'(3) << (RW - 2);
`ifdef PAGED_MMU_NOCACHE_BIT_EN
    localparam logic [RW-1:0] NC_MASK   = RW'(1) << (RW - 3);
`else
    localparam logic [RW-1:0] NC_MASK   = '0;
`endif
    localparam logic [RW-1:0] ENTRY_MASK = FLAG_MASK | NC_MASK | PPN_MASK;

    // Cacheable window [1/16, 1/2) of the physical space
    localparam logic [OUT_ADDR_W-1:0] CACHE_LO = OUT_ADDR_W'(1) << (OUT_ADDR_W - 4);
    localparam logic [OUT_ADDR_W-1:0] CACHE_HI = OUT_ADDR_W'(1) << (OUT_ADDR_W - 1);

    logic [RW-1:0]         table_q [ENTRIES];
    logic [IN_ADDR_W-1:0]  fault_addr;
    logic [1:0]            fault_cause;

    logic [PAGE_IDX_W-1:0] page;
    logic                  ent_v;
    logic                  ent_w;
    logic                  ent_nc;
    logic [PPN_W-1:0]      ppn;

    logic                  t_fault;
    logic [1:0]            t_cause;
    logic [OUT_ADDR_W-1:0] t_addr;
    logic                  t_cacheable;

    logic                  sr_in_tbl;
    logic [PAGE_IDX_W-1:0] sr_idx;
    logic                  sr_clr;

    assign page  = i_addr[IN_ADDR_W-1:OFF_W];
    assign ent_v = table_q[page][RW-1];
    assign ent_w = table_q[page][RW-2];
    assign ppn   = table_q[page][PPN_W-1:0];
`ifdef PAGED_MMU_NOCACHE_BIT_EN
    assign ent_nc = table_q[page][RW-3];
`else
    assign ent_nc = 1'b0;
`endif

    assign sr_in_tbl = (i_sr_addr >= SR_BASE) && (i_sr_addr < ENT_END);
    assign sr_idx    = PAGE_IDX_W'(i_sr_addr - SR_BASE);
    assign sr_clr    = i_sr_we && (i_sr_addr == FC_ADDR);

    // Translate the current request against the table as it stands this cycle
    always_comb begin
        t_fault     = 1'b0;
        t_cause     = 2'd0;
        t_addr      = {DEFAULT_PREFIX, i_addr};
        t_cacheable = 1'b0;
        if (c_pag_en) begin
            t_addr = {ppn, i_addr[OFF_W-1:0]};
            if (!ent_v) begin
                t_fault = 1'b1;
                t_cause = 2'd1;
            end else if (i_we && !ent_w) begin
                t_fault = 1'b1;
                t_cause = 2'd2;
            end
            if (t_fault) begin
                t_addr = '0;
            end
        end
        t_cacheable = !t_fault && !(c_pag_en && ent_nc)
                      && (t_addr >= CACHE_LO) && (t_addr < CACHE_HI);
    end

    // SR read mux: table entries, then fault status, else zero
    always_comb begin
        o_sr_rdata = '0;
        if (sr_in_tbl) begin
            o_sr_rdata = table_q[sr_idx];
        end else if (i_sr_addr == FA_ADDR) begin
            o_sr_rdata = RW'(fault_addr);
        end else if (i_sr_addr == FC_ADDR) begin
            o_sr_rdata = RW'(fault_cause);
        end
    end

    // Page table writes and sticky fault latch; a new fault beats a same-cycle clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
            fault_addr  <= '0;
            fault_cause <= 2'd0;
        end else begin
            if (i_sr_we && sr_in_tbl) begin
                table_q[sr_idx] <= i_sr_data & ENTRY_MASK;
            end
            if (i_req && t_fault && (fault_cause == 2'd0 || sr_clr)) begin
                fault_addr  <= i_addr;
                fault_cause <= t_cause;
            end else if (sr_clr) begin
                fault_addr  <= '0;
                fault_cause <= 2'd0;
            end
        end
    end

    // Result register: one-cycle latency, holds last result while idle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_addr      <= '0;
            o_fault     <= 1'b0;
            o_cacheable <= 1'b0;
        end else begin
            o_valid <= i_req;
            if (i_req) begin
                o_addr      <= t_addr;
                o_fault     <= t_fault;
                o_cacheable <= t_cacheable;
            end
        end
    end
endmodule

// File: tb/tb_paged_mmu.sv
// tb/tb_paged_mmu.sv - scoreboard testbench for paged_mmu
module tb_paged_mmu;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [15:0] i_addr = '0;
    logic        o_valid;
    logic [23:0] o_addr;
    logic        o_fault;
    logic        o_cacheable;
    logic [15:0] i_sr_addr = '0;
    logic [15:0] i_sr_data = '0;
    logic        i_sr_we = 1'b0;
    logic [15:0] o_sr_rdata;
    logic        c_pag_en = 1'b0;

    typedef struct {
        logic [23:0] addr;
        logic        fault;
        logic        cacheable;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

`ifdef PAGED_MMU_NOCACHE_BIT_EN
    localparam logic        NC_CACHE = 1'b0;
    localparam logic [15:0] E1_RB    = 16'hE100;
`else
    localparam logic        NC_CACHE = 1'b1;
    localparam logic [15:0] E1_RB    = 16'hC100;
`endif

    paged_mmu dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
        .o_valid(o_valid), .o_addr(o_addr), .o_fault(o_fault), .o_cacheable(o_cacheable),
        .i_sr_addr(i_sr_addr), .i_sr_data(i_sr_data), .i_sr_we(i_sr_we),
        .o_sr_rdata(o_sr_rdata), .c_pag_en(c_pag_en)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    // Drive one request for the coming edge and record its expected result
    task automatic req(input logic we, input logic [15:0] a,
                       input logic [23:0] ea, input logic ef, input logic ec);
        exp_t e;
        i_req = 1'b1;
        i_we = we;
        i_addr = a;
        e.addr = ea;
        e.fault = ef;
        e.cacheable = ec;
        exp_q.push_back(e);
        cycle();
    endtask

    task automatic idle();
        i_req = 1'b0;
        i_we = 1'b0;
        i_sr_we = 1'b0;
        cycle();
    endtask

    task automatic sr_wr(input logic [15:0] a, input logic [15:0] d);
        i_req = 1'b0;
        i_sr_we = 1'b1;
        i_sr_addr = a;
        i_sr_data = d;
        cycle();
        i_sr_we = 1'b0;
    endtask

    task automatic sr_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
        i_sr_addr = a;
        #1;
        chk(name, 32'(o_sr_rdata), 32'(exp));
    endtask

    // Monitor: every presented result must match the oldest expectation
    always @(negedge i_clk) begin
        if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_addr", 32'(o_addr), 32'(e.addr));
                chk("res_fault", 32'(o_fault), 32'(e.fault));
                chk("res_cacheable", 32'(o_cacheable), 32'(e.cacheable));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cycle();
        i_rst = 1'b0;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_addr", 32'(o_addr), 0);
        chk("rst_fault", 32'(o_fault), 0);
        chk("rst_cacheable", 32'(o_cacheable), 0);
        sr_chk("rst_fault_addr", 16'h210, 16'h0000);
        sr_chk("rst_fault_cause", 16'h211, 16'h0000);

        // Paging disabled: default prefix
        c_pag_en = 1'b0;
        req(1'b0, 16'h1234, 24'h101234, 1'b0, 1'b1);
        idle();
        idle();
        chk("hold_addr", 32'(o_addr), 32'h101234);
        chk("hold_valid", 32'(o_valid), 0);

        // Basic translation
        sr_wr(16'h203, 16'hC0AB);
        sr_chk("entry3_rb", 16'h203, 16'hC0AB);
        c_pag_en = 1'b1;
        req(1'b0, 16'h3456, 24'h0AB456, 1'b0, 1'b0);
        idle();

        // Write-permission fault
        sr_wr(16'h205, 16'h8010);
        req(1'b0, 16'h5001, 24'h010001, 1'b0, 1'b0);
        req(1'b1, 16'h5001, 24'h000000, 1'b1, 1'b0);
        idle();
        sr_chk("fa_perm", 16'h210, 16'h5001);
        sr_chk("fc_perm", 16'h211, 16'h0002);

        // Sticky: invalid-page fault does not overwrite
        req(1'b0, 16'h7000, 24'h000000, 1'b1, 1'b0);
        idle();
        sr_chk("fa_sticky", 16'h210, 16'h5001);
        sr_chk("fc_sticky", 16'h211, 16'h0002);
        sr_wr(16'h210, 16'hFFFF);
        sr_chk("fa_wr_ignored", 16'h210, 16'h5001);
        sr_wr(16'h211, 16'h1234);
        sr_chk("fa_cleared", 16'h210, 16'h0000);
        sr_chk("fc_cleared", 16'h211, 16'h0000);
        req(1'b0, 16'h7000, 24'h000000, 1'b1, 1'b0);
        idle();
        sr_chk("fa_invalid", 16'h210, 16'h7000);
        sr_chk("fc_invalid", 16'h211, 16'h0001);

        // Clear and new fault in the same cycle: new fault wins
        i_sr_we = 1'b1;
        i_sr_addr = 16'h211;
        i_sr_data = 16'h0000;
        req(1'b0, 16'h7123, 24'h000000, 1'b1, 1'b0);
        idle();
        sr_chk("fa_clr_race", 16'h210, 16'h7123);
        sr_chk("fc_clr_race", 16'h211, 16'h0001);

        // Back-to-back stream with a mid-stream rewrite of the active page
        sr_wr(16'h202, 16'h8300);
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                i_sr_we = 1'b1;
                i_sr_addr = 16'h202;
                i_sr_data = 16'h8900;
            end else begin
                i_sr_we = 1'b0;
            end
            if (i <= 8)
                req(1'b0, 16'h2000 + 16'(i), 24'h300000 + 24'(i), 1'b0, 1'b1);
            else
                req(1'b0, 16'h2000 + 16'(i), 24'h900000 + 24'(i), 1'b0, 1'b0);
            chk("stream_valid", 32'(o_valid), 1);
        end
        idle();

        // Cacheable window boundaries
        sr_wr(16'h203, 16'hC0FF);
        sr_wr(16'h204, 16'hC7FF);
        sr_wr(16'h206, 16'hC800);
        sr_wr(16'h201, 16'hE100);
        sr_chk("entry1_rb", 16'h201, E1_RB);
        req(1'b0, 16'h3FFF, 24'h0FFFFF, 1'b0, 1'b0);
        req(1'b0, 16'h4FFF, 24'h7FFFFF, 1'b0, 1'b1);
        req(1'b0, 16'h6000, 24'h800000, 1'b0, 1'b0);
        req(1'b0, 16'h1000, 24'h100000, 1'b0, NC_CACHE);
        idle();
        sr_chk("oor_high", 16'h212, 16'h0000);
        sr_chk("oor_low", 16'h1FF, 16'h0000);

        // Reset with a request in flight drops it
        i_req = 1'b1;
        i_addr = 16'h4000;
        i_rst = 1'b1;
        cycle();
        i_req = 1'b0;
        i_rst = 1'b0;
        chk("rst_inflight_valid", 32'(o_valid), 0);
        chk("rst_inflight_addr", 32'(o_addr), 0);
        sr_chk("rst_entry_cleared", 16'h204, 16'h0000);
        idle();
        idle();

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/paged_mmu.md
Name: paged_mmu

Overview:
Parametrised data-side paging unit, the next generation of the fixed 16-entry data MMU. It translates core virtual addresses to bus physical addresses through an SR-programmed page table, with per-page valid and write-permission bits. Translation is registered behind a valid handshake, and faults are latched into sticky status registers readable over the SR bus. It sits between the core load/store stage and the memory arbiter/cache.

Parameters:
RW, 16, SR bus data/address width.
IN_ADDR_W, 16, virtual address width.
OUT_ADDR_W, 24, physical address width.
PAGE_IDX_W, 4, page index bits; entries = 2**PAGE_IDX_W; offset width OFF_W = IN_ADDR_W-PAGE_IDX_W.
SR_BASE, 16'h200, SR address of entry 0; FAULT_ADDR at SR_BASE+ENTRIES, FAULT_CAUSE at SR_BASE+ENTRIES+1.
DEFAULT_PREFIX, 8'h10, upper bits used when paging is disabled; width OUT_ADDR_W-IN_ADDR_W.
Constraint: PPN_W = OUT_ADDR_W-OFF_W must be <= RW-3.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req  in  1  translation request valid
i_we  in  1  request is a store
i_addr  in  IN_ADDR_W  virtual address
o_valid  out  1  registered result valid
o_addr  out  OUT_ADDR_W  translated address
o_fault  out  1  result is a fault; o_addr is 0
o_cacheable  out  1  result address is cacheable
i_sr_addr  in  RW  SR address
i_sr_data  in  RW  SR write data
i_sr_we  in  1  SR write strobe
o_sr_rdata  out  RW  combinational SR read data; 0 when out of range
c_pag_en  in  1  paging enable

Behaviour:
- Reset is synchronous, active-high (i_rst) on clock i_clk. On reset: all entries 0 (invalid), o_valid=0, o_fault=0, o_addr=0, o_cacheable=0, FAULT_ADDR=0, FAULT_CAUSE=0.
- Entry format: [RW-1] V (valid), [RW-2] W (writable), [PPN_W-1:0] PPN. Other bits read back as 0.
- SR write with i_sr_we and SR_BASE <= i_sr_addr < SR_BASE+ENTRIES stores entry (i_sr_addr-SR_BASE). A write to FAULT_CAUSE clears FAULT_CAUSE and FAULT_ADDR; the data is ignored. A write to FAULT_ADDR is ignored.
- Pipeline: fixed 1-cycle latency, throughput 1 request per cycle, no stall. o_valid(t+1)=i_req(t). Outputs hold their last value while o_valid=0.
- Translation with c_pag_en=1: o_addr={PPN, offset}. Fault if V=0 (cause 1) or if i_we=1 and W=0 (cause 2). A fault gives o_fault=1, o_addr=0, o_cacheable=0.
- Translation with c_pag_en=0: o_addr={DEFAULT_PREFIX, i_addr}. Never faults.
- o_cacheable=1 iff there is no fault and 24'h100000 <= o_addr < 24'h800000 (bounds scaled to OUT_ADDR_W).
- Fault latch: FAULT_CAUSE is 2 bits, sticky. On a fault while FAULT_CAUSE==0, latch FAULT_ADDR=i_addr and FAULT_CAUSE=cause. Later faults do not overwrite. If a clear and a new fault occur in the same cycle, the new fault wins.
- Same-cycle SR write to entry k and request on page k: the translation uses the old entry. The new entry takes effect from the next cycle.
- c_pag_en is sampled in the request cycle.
- Reset during an in-flight request: the request is dropped and o_valid=0 on the next cycle.

Optional Feature:
Macro PAGED_MMU_NOCACHE_BIT_EN.
- Defined: entry bit [RW-3] is NC, stored and read back. NC=1 forces o_cacheable=0 for that page when paging is enabled. The constraint tightens to PPN_W <= RW-4.
- Undefined: bit [RW-3] is not stored and reads 0. o_cacheable depends only on the address range.

Test Plan:
- Reset, then c_pag_en=0, req addr 16'h1234 -> next cycle o_valid=1, o_addr=24'h101234, o_fault=0, o_cacheable=1.
- SR write 0x203 <= 16'hC0AB, c_pag_en=1, read req 16'h3456 -> o_addr=24'h0AB456, o_fault=0, o_cacheable=0. SR read 0x203 returns 16'hC0AB.
- Entry 5 = 16'h8010 (V=1, W=0): read req 16'h5001 -> o_addr=24'h010001. Store req 16'h5001 -> o_fault=1, o_addr=0. FAULT_ADDR=16'h5001, FAULT_CAUSE=2.
- Then read req to invalid page 16'h7000 -> o_fault=1, but FAULT_ADDR stays 16'h5001. SR write 0x211 -> FAULT_CAUSE=0. Repeat the request -> FAULT_ADDR=16'h7000, FAULT_CAUSE=1.
- Back-to-back reqs every cycle for 16 cycles with an SR write to the active page mid-stream -> o_valid continuous; the first result after the write uses the old PPN, later results use the new PPN.
- With PAGED_MMU_NOCACHE_BIT_EN: entry 1 = 16'hE100 -> req 16'h1000 gives o_cacheable=0. Without the macro the same req gives o_cacheable=1 and SR read 0x201 returns 16'hC100.
